// File: rtl/bc_round_ctrl.sv
// Bulls-and-cows round sequencer: secret capture, guess entry, four-cycle
// digit-serial scoring, timed result display and win/lose tracking.
module bc_round_ctrl #(
    parameter int DISP_CYCLES = 4,
    parameter int MAX_TRIES   = 10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        save,
    input  logic [11:0] digits_in,
    input  logic        new_game,
    output logic [2:0]  phase,
    output logic [2:0]  bulls,
    output logic [2:0]  cows,
    output logic [3:0]  tries,
    output logic        result_valid,
    output logic        err_dup,
    output logic [11:0] secret_out,
    output logic        game_over
);

    typedef enum logic [2:0] {
        ST_SECRET = 3'd0,
        ST_GUESS  = 3'd1,
        ST_SCORE  = 3'd2,
        ST_SHOW   = 3'd3,
        ST_WIN    = 3'd4,
        ST_LOSE   = 3'd5
    } state_t;

    localparam int             CW          = (DISP_CYCLES > 1) ? $clog2(DISP_CYCLES) : 1;
    localparam logic [CW-1:0]  DISP_LAST   = CW'(DISP_CYCLES - 1);
    localparam logic [3:0]     TRIES_LIMIT = 4'(MAX_TRIES);

    state_t         state_reg,    state_next;
    logic [11:0]    secret_reg,   secret_next;
    logic [11:0]    guess_reg,    guess_next;
    logic [2:0]     bull_acc_reg, bull_acc_next;
    logic [2:0]     cow_acc_reg,  cow_acc_next;
    logic [1:0]     idx_reg,      idx_next;
    logic [CW-1:0]  disp_cnt_reg, disp_cnt_next;
    logic [2:0]     bulls_reg,    bulls_next;
    logic [2:0]     cows_reg,     cows_next;
    logic [3:0]     tries_reg,    tries_next;
    logic           rv_reg,       rv_next;
    logic           err_reg,      err_next;

    // Unpacked digit views of the input, the secret and the stored guess
    logic [2:0] in_dig  [4];
    logic [2:0] sec_dig [4];
    logic [2:0] gss_dig [4];
    logic [3:0] match;
    logic [2:0] cur_guess;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_digits
            assign in_dig[gi]  = digits_in[gi*3 +: 3];
            assign sec_dig[gi] = secret_reg[gi*3 +: 3];
            assign gss_dig[gi] = guess_reg[gi*3 +: 3];
            // Current guess digit against every secret position
            assign match[gi]   = (cur_guess == sec_dig[gi]);
        end
    endgenerate

    assign cur_guess = gss_dig[idx_reg];

    // A code is accepted only when all four digits are pairwise different
    logic code_valid;
    assign code_valid = (in_dig[0] != in_dig[1]) && (in_dig[0] != in_dig[2]) &&
                        (in_dig[0] != in_dig[3]) && (in_dig[1] != in_dig[2]) &&
                        (in_dig[1] != in_dig[3]) && (in_dig[2] != in_dig[3]);

    // Same position is a bull; any other position is a cow
    logic bull_hit;
    logic cow_hit;
    assign bull_hit = match[idx_reg];
    assign cow_hit  = |(match & ~(4'b0001 << idx_reg));

    logic [2:0] bull_sum;
    logic [2:0] cow_sum;
    assign bull_sum = bull_acc_reg + {2'b00, bull_hit};
    assign cow_sum  = cow_acc_reg  + {2'b00, cow_hit};

    // Next-state and datapath update; new_game overrides everything else
    always_comb begin
        state_next    = state_reg;
        secret_next   = secret_reg;
        guess_next    = guess_reg;
        bull_acc_next = bull_acc_reg;
        cow_acc_next  = cow_acc_reg;
        idx_next      = idx_reg;
        disp_cnt_next = disp_cnt_reg;
        bulls_next    = bulls_reg;
        cows_next     = cows_reg;
        tries_next    = tries_reg;
        rv_next       = 1'b0;
        err_next      = 1'b0;

        case (state_reg)
            ST_SECRET: begin
                if (save) begin
                    if (code_valid) begin
                        secret_next = digits_in;
                        state_next  = ST_GUESS;
                    end else begin
                        err_next = 1'b1;
                    end
                end
            end
            ST_GUESS: begin
                if (save) begin
                    if (code_valid) begin
                        guess_next    = digits_in;
                        tries_next    = tries_reg + 4'd1;
                        bull_acc_next = 3'd0;
                        cow_acc_next  = 3'd0;
                        idx_next      = 2'd0;
                        state_next    = ST_SCORE;
                    end else begin
                        err_next = 1'b1;
                    end
                end
            end
            ST_SCORE: begin
                bull_acc_next = bull_sum;
                cow_acc_next  = cow_sum;
                idx_next      = idx_reg + 2'd1;
                if (idx_reg == 2'd3) begin
                    bulls_next    = bull_sum;
                    cows_next     = cow_sum;
                    rv_next       = 1'b1;
                    disp_cnt_next = '0;
                    state_next    = ST_SHOW;
                end
            end
            ST_SHOW: begin
                if (disp_cnt_reg == DISP_LAST) begin
                    if (bulls_reg == 3'd4)
                        state_next = ST_WIN;
                    else if (tries_reg == TRIES_LIMIT)
                        state_next = ST_LOSE;
                    else
                        state_next = ST_GUESS;
                end else begin
                    disp_cnt_next = disp_cnt_reg + CW'(1);
                end
            end
            ST_WIN, ST_LOSE: begin
                state_next = state_reg;
            end
            default: begin
                state_next = ST_SECRET;
            end
        endcase

        if (new_game) begin
            state_next    = ST_SECRET;
            secret_next   = '0;
            guess_next    = '0;
            bull_acc_next = '0;
            cow_acc_next  = '0;
            idx_next      = '0;
            disp_cnt_next = '0;
            bulls_next    = '0;
            cows_next     = '0;
            tries_next    = '0;
            rv_next       = 1'b0;
            err_next      = 1'b0;
        end
    end

    // State and datapath registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg    <= ST_SECRET;
            secret_reg   <= '0;
            guess_reg    <= '0;
            bull_acc_reg <= '0;
            cow_acc_reg  <= '0;
            idx_reg      <= '0;
            disp_cnt_reg <= '0;
            bulls_reg    <= '0;
            cows_reg     <= '0;
            tries_reg    <= '0;
            rv_reg       <= 1'b0;
            err_reg      <= 1'b0;
        end else begin
            state_reg    <= state_next;
            secret_reg   <= secret_next;
            guess_reg    <= guess_next;
            bull_acc_reg <= bull_acc_next;
            cow_acc_reg  <= cow_acc_next;
            idx_reg      <= idx_next;
            disp_cnt_reg <= disp_cnt_next;
            bulls_reg    <= bulls_next;
            cows_reg     <= cows_next;
            tries_reg    <= tries_next;
            rv_reg       <= rv_next;
            err_reg      <= err_next;
        end
    end

    assign phase        = state_reg;
    assign bulls        = bulls_reg;
    assign cows         = cows_reg;
    assign tries        = tries_reg;
    assign result_valid = rv_reg;
    assign err_dup      = err_reg;
    assign secret_out   = secret_reg;
    assign game_over    = (state_reg == ST_WIN) || (state_reg == ST_LOSE);

endmodule

// File: tb/tb_bc_round_ctrl.sv
// Self-checking bench for bc_round_ctrl: directed scenarios plus random games
// compared against a transaction-level model of the game rules.
module tb_bc_round_ctrl;

    localparam int DISP = 4;
    localparam int MAXT = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        save = 1'b0;
    logic [11:0] digits_in = '0;
    logic        new_game = 1'b0;
    logic [2:0]  phase, bulls, cows;
    logic [3:0]  tries;
    logic        result_valid, err_dup, game_over;
    logic [11:0] secret_out;

    bc_round_ctrl #(.DISP_CYCLES(DISP), .MAX_TRIES(MAXT)) dut (
        .clk(clk), .rst_n(rst_n), .save(save), .digits_in(digits_in),
        .new_game(new_game), .phase(phase), .bulls(bulls), .cows(cows),
        .tries(tries), .result_valid(result_valid), .err_dup(err_dup),
        .secret_out(secret_out), .game_over(game_over)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Game-level model
    int          m_phase;
    logic [11:0] m_secret;
    int          m_tries, m_bulls, m_cows;

    task automatic chk(input string tag, input int unsigned got, input int unsigned exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    function automatic int dig(input logic [11:0] code, input int i);
        return int'((code >> (3*i)) & 12'h7);
    endfunction

    function automatic bit distinct(input logic [11:0] code);
        for (int i = 0; i < 4; i++)
            for (int j = i + 1; j < 4; j++)
                if (dig(code, i) == dig(code, j)) return 1'b0;
        return 1'b1;
    endfunction

    task automatic score(input logic [11:0] g, input logic [11:0] s, output int b, output int c);
        b = 0; c = 0;
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++)
                if (dig(g, i) == dig(s, j)) begin
                    if (i == j) b++; else c++;
                end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        m_phase = 0; m_secret = '0; m_tries = 0; m_bulls = 0; m_cows = 0;
    endtask

    task automatic check_all(input string tag, input int rv, input int ed);
        chk({tag, ".phase"}, phase, m_phase);
        chk({tag, ".rv"}, result_valid, rv);
        chk({tag, ".err"}, err_dup, ed);
        chk({tag, ".bulls"}, bulls, m_bulls);
        chk({tag, ".cows"}, cows, m_cows);
        chk({tag, ".tries"}, tries, m_tries);
        chk({tag, ".secret"}, secret_out, m_secret);
        chk({tag, ".over"}, game_over, (m_phase == 4 || m_phase == 5) ? 1 : 0);
        $display("[%0t] %s phase=%0d b=%0d c=%0d tries=%0d rv=%0d err=%0d",
                 $time, tag, phase, bulls, cows, tries, result_valid, err_dup);
    endtask

    // One save transaction, followed through scoring and display if accepted
    task automatic do_save(input logic [11:0] code, input string tag);
        int b, c;
        save = 1'b1; digits_in = code;
        tick();
        save = 1'b0;
        if (m_phase == 0 && distinct(code)) begin
            m_secret = code; m_phase = 1;
            check_all({tag, ".sec"}, 0, 0);
        end else if (m_phase == 1 && distinct(code)) begin
            m_tries++; m_phase = 2;
            check_all({tag, ".sc0"}, 0, 0);
            repeat (3) begin tick(); check_all({tag, ".sc"}, 0, 0); end
            tick();
            score(code, m_secret, b, c);
            m_bulls = b; m_cows = c; m_phase = 3;
            check_all({tag, ".show"}, 1, 0);
            repeat (DISP - 1) begin tick(); check_all({tag, ".hold"}, 0, 0); end
            tick();
            m_phase = (m_bulls == 4) ? 4 : (m_tries == MAXT) ? 5 : 1;
            check_all({tag, ".exit"}, 0, 0);
        end else if (m_phase <= 1) begin
            check_all({tag, ".dup"}, 0, 1);
            tick();
            check_all({tag, ".dup1"}, 0, 0);
        end else begin
            check_all({tag, ".ign"}, 0, 0);
        end
    endtask

    task automatic do_new_game(input bit with_save);
        new_game = 1'b1; save = with_save; digits_in = 12'($urandom_range(0, 4095));
        tick();
        new_game = 1'b0; save = 1'b0;
        model_clear();
        check_all("newgame", 0, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1);
    end

    initial begin
        logic [11:0] code;
        model_clear();
        // Reset state
        rst_n = 1'b0;
        tick(); tick();
        check_all("reset", 0, 0);
        rst_n = 1'b1;

        // Scenario 1 and 3: secret, scored guess, then winning guess
        do_save(12'h688, "t1");
        do_save(12'h40B, "t1g");
        do_save(12'h688, "t3win");
        do_save(12'h40B, "t3ign");

        // Scenario 2: duplicate secret rejected, then valid one accepted
        do_new_game(1'b0);
        do_save(12'h46D, "t2dup");
        do_save(12'h688, "t2ok");

        // Scenario 4: two wrong guesses lose, third save ignored
        do_save(12'h40B, "t4a");
        do_save(12'h40B, "t4b");
        do_save(12'h40B, "t4ign");

        // Scenario 5: new_game with save during SCORE cycle 2
        do_new_game(1'b0);
        do_save(12'h688, "t5sec");
        save = 1'b1; digits_in = 12'h40B;
        tick();
        save = 1'b0;
        m_tries++; m_phase = 2;
        check_all("t5sc1", 0, 0);
        tick();
        check_all("t5sc2", 0, 0);
        new_game = 1'b1; save = 1'b1; digits_in = 12'h46D;
        tick();
        new_game = 1'b0; save = 1'b0;
        model_clear();
        check_all("t5abort", 0, 0);
        repeat (6) begin tick(); check_all("t5quiet", 0, 0); end

        // Scenario 6: reset asserted during SHOW
        do_save(12'h688, "t6sec");
        save = 1'b1; digits_in = 12'h40B;
        tick();
        save = 1'b0;
        repeat (4) tick();
        m_tries = 1; m_phase = 3; m_bulls = 1; m_cows = 3;
        check_all("t6show", 1, 0);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        model_clear();
        check_all("t6reset", 0, 0);

        // Random games
        for (int g = 0; g < 25; g++) begin
            do_new_game(1'($urandom_range(0, 1)));
            for (int s = 0; s < 12 && m_phase != 4 && m_phase != 5; s++) begin
                code = 12'($urandom_range(0, 4095));
                if (m_phase == 1 && $urandom_range(0, 3) == 0) code = m_secret;
                do_save(code, "rnd");
            end
            do_save(12'($urandom_range(0, 4095)), "rndend");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
